// File: rtl/mem_pkg.sv
// Shared types and constants for the core-memory cycle controller and its select drivers.
package mem_pkg;

   localparam int unsigned CntW   = 8;
   localparam int unsigned SelW   = 3;
   localparam int unsigned AddrW  = 12;

   localparam int unsigned AxLsb  = 0;
   localparam int unsigned AyLsb  = 3;
   localparam int unsigned Ax0Lsb = 6;
   localparam int unsigned Ay0Lsb = 9;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StSetup  = 3'd1,
      StRsync  = 3'd2,
      StRsense = 3'd3,
      StSsync  = 3'd4,
      StSrecov = 3'd5
   } mem_state_e;

endpackage

// File: rtl/mem_onehot_drv.sv
// Registered 3-to-8 active-low select decoder; drives all ones when disabled.
module mem_onehot_drv
   import mem_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_en,
   input  logic [SelW-1:0] i_sel,
   output logic [7:0]      o_sel_n
);

   logic [7:0] r_sel_n;
   logic [7:0] w_sel_n;

   always_comb begin
      w_sel_n = 8'hFF;
      if (i_en) begin
         w_sel_n[i_sel] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_n <= 8'hFF;
      end else begin
         r_sel_n <= w_sel_n;
      end
   end

   assign o_sel_n = r_sel_n;

endmodule

// File: rtl/mem_cycle_ctrl.sv
// Core-memory cycle sequencer: destructive read, sense capture, restore.
// Optional MEM_CYCLE_ABORT_EN adds an abort input honoured only during SETUP.
module mem_cycle_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_SYNC  = 4,
   parameter int unsigned T_READ  = 6,
   parameter int unsigned T_STORE = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic [AddrW-1:0] addr,
   output logic [7:0]       ax_n,
   output logic [7:0]       ay_n,
   output logic [7:0]       ax0_n,
   output logic [7:0]       ay0_n,
   output logic             AnRDMV,
   output logic             AnRDMVN,
   output logic             AnINHBSV,
   output logic             MmSYNCV,
   input  logic             EDmX,
   input  logic             EDmY,
`ifdef MEM_CYCLE_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic             rd_x,
   output logic             rd_y
);

   mem_state_e       r_state;
   mem_state_e       w_state_d;
   logic [CntW-1:0]  r_cnt;
   logic [CntW-1:0]  w_cnt_d;
   logic [CntW-1:0]  w_len;
   logic             w_last;
   logic             w_abort;
   logic [AddrW-1:0] r_addr;
   logic [AddrW-1:0] w_addr;
   logic             w_sel_en;

   logic w_rdmv, w_sync, w_inh, w_busy, w_done, w_cap;
   logic r_rdmv, r_rdmvn, r_sync, r_inh, r_busy, r_done, r_rd_x, r_rd_y;

`ifdef MEM_CYCLE_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   always_comb begin
      w_len = CntW'(1);
      case (r_state)
         StSetup:          w_len = CntW'(T_SETUP);
         StRsync, StSsync: w_len = CntW'(T_SYNC);
         StRsense:         w_len = CntW'(T_READ);
         StSrecov:         w_len = CntW'(T_STORE);
         default:          w_len = CntW'(1);
      endcase
   end

   assign w_last = (r_cnt == (w_len - CntW'(1)));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle: begin
            if (req) w_state_d = StSetup;
         end
         StSetup: begin
            if (w_abort)     w_state_d = StIdle;
            else if (w_last) w_state_d = StRsync;
         end
         StRsync: begin
            if (w_last) w_state_d = StRsense;
         end
         StRsense: begin
            if (w_last) w_state_d = StSsync;
         end
         StSsync: begin
            if (w_last) w_state_d = StSrecov;
         end
         StSrecov: begin
            if (w_last) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_comb begin
      if ((w_state_d != r_state) || (r_state == StIdle)) begin
         w_cnt_d = '0;
      end else begin
         w_cnt_d = r_cnt + CntW'(1);
      end
   end

   // Output logic, decoded from the next state so registered outputs align with it
   always_comb begin
      w_rdmv = 1'b0;
      w_sync = 1'b0;
      w_inh  = 1'b0;
      w_busy = (w_state_d != StIdle);
      case (w_state_d)
         StSetup:  w_rdmv = 1'b1;
         StRsync: begin
            w_rdmv = 1'b1;
            w_sync = 1'b1;
         end
         StRsense: begin
            w_rdmv = 1'b1;
            w_inh  = 1'b1;
         end
         StSsync:  w_sync = 1'b1;
         default:  w_rdmv = 1'b0;
      endcase
      w_done = (r_state == StSrecov) && (w_state_d == StIdle);
      w_cap  = (r_state == StRsense) && w_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdmv  <= 1'b0;
         r_rdmvn <= 1'b1;
         r_sync  <= 1'b0;
         r_inh   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rd_x  <= 1'b0;
         r_rd_y  <= 1'b0;
      end else begin
         r_rdmv  <= w_rdmv;
         r_rdmvn <= ~w_rdmv;
         r_sync  <= w_sync;
         r_inh   <= w_inh;
         r_busy  <= w_busy;
         r_done  <= w_done;
         if (w_cap) begin
            r_rd_x <= EDmX;
            r_rd_y <= EDmY;
         end
      end
   end

   // The incoming address feeds the decoders on the starting edge, then the latch holds it
   assign w_addr   = (r_state == StIdle) ? addr : r_addr;
   assign w_sel_en = (w_state_d != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
      end else if ((r_state == StIdle) && req) begin
         r_addr <= addr;
      end
   end

   mem_onehot_drv u_drv_ax (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_sel_en),
      .i_sel   (w_addr[AxLsb +: SelW]),
      .o_sel_n (ax_n)
   );

   mem_onehot_drv u_drv_ay (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_sel_en),
      .i_sel   (w_addr[AyLsb +: SelW]),
      .o_sel_n (ay_n)
   );

   mem_onehot_drv u_drv_ax0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_sel_en),
      .i_sel   (w_addr[Ax0Lsb +: SelW]),
      .o_sel_n (ax0_n)
   );

   mem_onehot_drv u_drv_ay0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_sel_en),
      .i_sel   (w_addr[Ay0Lsb +: SelW]),
      .o_sel_n (ay0_n)
   );

   assign AnRDMV   = r_rdmv;
   assign AnRDMVN  = r_rdmvn;
   assign AnINHBSV = r_inh;
   assign MmSYNCV  = r_sync;
   assign busy     = r_busy;
   assign done     = r_done;
   assign rd_x     = r_rd_x;
   assign rd_y     = r_rd_y;

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Self-checking bench for mem_cycle_ctrl: vector table, per-cycle timing model, sense scoreboard.
module tb_mem_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req;
   logic [11:0] addr;
   logic        EDmX, EDmY;
   logic [7:0]  ax_n, ay_n, ax0_n, ay0_n;
   logic        AnRDMV, AnRDMVN, AnINHBSV, MmSYNCV;
   logic        busy, done, rd_x, rd_y;
`ifdef MEM_CYCLE_ABORT_EN
   logic        abort;
`endif

   mem_cycle_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .addr     (addr),
      .ax_n     (ax_n),
      .ay_n     (ay_n),
      .ax0_n    (ax0_n),
      .ay0_n    (ay0_n),
      .AnRDMV   (AnRDMV),
      .AnRDMVN  (AnRDMVN),
      .AnINHBSV (AnINHBSV),
      .MmSYNCV  (MmSYNCV),
      .EDmX     (EDmX),
      .EDmY     (EDmY),
`ifdef MEM_CYCLE_ABORT_EN
      .abort    (abort),
`endif
      .busy     (busy),
      .done     (done),
      .rd_x     (rd_x),
      .rd_y     (rd_y)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] addr;
      logic        edx;
      logic        edy;
      logic [7:0]  ax;
      logic [7:0]  ay;
      logic [7:0]  ax0;
      logic [7:0]  ay0;
      logic        hold_req;
      int          abort_cyc;
   } vec_t;

   typedef struct {
      logic rx;
      logic ry;
   } exp_t;

   localparam int unsigned BusyLen = 22;

   vec_t vecs[5];
   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input int cyc, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {busy, sync, rdmv, rdmvn, inh, done} for cycle c of a transaction; 0 means idle
   function automatic logic [5:0] exp_ctl(input int c);
      logic s, r, i;
      if (c == 0) return 6'b000100;
      if (c == BusyLen + 1) return 6'b000101;
      s = ((c >= 3) && (c <= 6)) || ((c >= 13) && (c <= 16));
      r = (c <= 12);
      i = (c >= 7) && (c <= 12);
      return {1'b1, s, r, ~r, i, 1'b0};
   endfunction

   task automatic run_cycle(input vec_t v);
      exp_t e;
      exp_t got;
      addr = v.addr;
      req  = 1'b1;
      EDmX = ~v.edx;
      EDmY = ~v.edy;
      e.rx = v.edx;
      e.ry = v.edy;
      sb_q.push_back(e);
      tick();
      if (!v.hold_req) req = 1'b0;
      for (int c = 1; c <= int'(BusyLen); c++) begin
         check("ctl", c, 32'({busy, MmSYNCV, AnRDMV, AnRDMVN, AnINHBSV, done}), 32'(exp_ctl(c)));
         check("sel", c, {ax_n, ay_n, ax0_n, ay0_n}, {v.ax, v.ay, v.ax0, v.ay0});
         addr = 12'($urandom);
         if (c == 12) begin
            EDmX = v.edx;
            EDmY = v.edy;
         end else begin
            EDmX = ~v.edx;
            EDmY = ~v.edy;
         end
         if (c == 10) req = 1'b1;
         if ((c == 11) && !v.hold_req) req = 1'b0;
`ifdef MEM_CYCLE_ABORT_EN
         abort = (c == v.abort_cyc);
`endif
         tick();
      end
`ifdef MEM_CYCLE_ABORT_EN
      abort = 1'b0;
`endif
      check("ctl_done", BusyLen + 1, 32'({busy, MmSYNCV, AnRDMV, AnRDMVN, AnINHBSV, done}),
            32'(exp_ctl(BusyLen + 1)));
      check("sel_idle", BusyLen + 1, {ax_n, ay_n, ax0_n, ay0_n}, 32'hFFFF_FFFF);
      if (sb_q.size() == 0) begin
         check("sb_empty", BusyLen + 1, 32'd1, 32'd0);
      end else begin
         got = sb_q.pop_front();
         check("rd_xy", BusyLen + 1, 32'({rd_x, rd_y}), 32'({got.rx, got.ry}));
      end
   endtask

   initial begin
      vecs[0] = '{12'o7531, 1'b1, 1'b0, 8'hFD, 8'hF7, 8'hDF, 8'h7F, 1'b0, 0};
      vecs[1] = '{12'o0000, 1'b0, 1'b1, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 1'b1, 0};
      vecs[2] = '{12'o1234, 1'b1, 1'b1, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 1'b1, 0};
      vecs[3] = '{12'o7777, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0, 3};
      vecs[4] = '{12'o6420, 1'b1, 1'b0, 8'hFE, 8'hFB, 8'hEF, 8'hBF, 1'b0, 0};

      req  = 1'b0;
      addr = '0;
      EDmX = 1'b0;
      EDmY = 1'b0;
`ifdef MEM_CYCLE_ABORT_EN
      abort = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #2;
      check("rst_ctl", 0, 32'({busy, MmSYNCV, AnRDMV, AnRDMVN, AnINHBSV, done}), 32'(exp_ctl(0)));
      check("rst_sel", 0, {ax_n, ay_n, ax0_n, ay0_n}, 32'hFFFF_FFFF);
      check("rst_rd", 0, 32'({rd_x, rd_y}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_cycle(vecs[i]);
         if (!vecs[i].hold_req) begin
            tick();
            check("idle_ctl", 0, 32'({busy, MmSYNCV, AnRDMV, AnRDMVN, AnINHBSV, done}),
                  32'(exp_ctl(0)));
            check("rd_hold", 0, 32'({rd_x, rd_y}), 32'({vecs[i].edx, vecs[i].edy}));
         end
         if (i == 0) begin
            // Abandon a cycle mid-RSENSE; reset must act without a clock edge
            addr = 12'o7531;
            req  = 1'b1;
            tick();
            req = 1'b0;
            repeat (8) tick();
            check("pre_rst_inh", 9, 32'(AnINHBSV), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            check("arst_sel", 9, {ax_n, ay_n, ax0_n, ay0_n}, 32'hFFFF_FFFF);
            check("arst_ctl", 9, 32'({busy, MmSYNCV, AnRDMV, AnRDMVN, AnINHBSV, done}),
                  32'(exp_ctl(0)));
            check("arst_rd", 9, 32'({rd_x, rd_y}), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            tick();
            check("post_rst", 0, 32'({busy, MmSYNCV, AnRDMV, AnRDMVN, AnINHBSV, done}),
                  32'(exp_ctl(0)));
         end
      end

`ifdef MEM_CYCLE_ABORT_EN
      addr = 12'o1234;
      req  = 1'b1;
      tick();
      req = 1'b0;
      check("ab_setup_sel", 1, {ax_n, ay_n, ax0_n, ay0_n}, 32'hEFF7_FBFD);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("ab_idle_ctl", k, 32'({busy, MmSYNCV, AnRDMV, AnRDMVN, AnINHBSV, done}),
               32'(exp_ctl(0)));
         check("ab_idle_sel", k, {ax_n, ay_n, ax0_n, ay0_n}, 32'hFFFF_FFFF);
         check("ab_rd_hold", k, 32'({rd_x, rd_y}), 32'({vecs[4].edx, vecs[4].edy}));
         tick();
      end
      run_cycle(vecs[3]);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
